// File: rtl/multi_cycle_mips_core.sv
// Multi-cycle, non-pipelined 32-bit MIPS integer core with one shared ALU and a
// unified asynchronous instruction/data memory port.

module mips_regfile (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);
  logic [31:0] rf_data [32];

  // Entry 0 is rewritten with zero every cycle so it reads 0 even hierarchically.
  always_ff @(posedge clk) begin
    if (we && (waddr != 5'd0)) rf_data[waddr] <= wdata;
    rf_data[0] <= '0;
  end

  assign rdata1 = (raddr1 == 5'd0) ? '0 : rf_data[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? '0 : rf_data[raddr2];
endmodule

module multi_cycle_mips_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MEM_WAIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_read_data,
  output logic [31:0] mem_write_data,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  mem_write_data_src
);
  typedef enum logic [2:0] {
    FETCH, DECODE, EXECUTE, MEM_READ, MEM_WRITE, WB_ALU, WB_MEM
  } state_t;

  state_t      state, next_state;
  logic [31:0] PC, IR, MDR, A, B, ALUOut;
  logic [7:0]  wait_cnt;
  logic        wait_last, mem_state;
  logic [31:0] alu_y, sext_imm, zext_imm, rs_val, rt_val;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic        is_r, r_ok, is_jr, is_ialu, is_lw, is_store, is_br, is_j, is_jal, valid;
  logic        br_taken, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  assign op       = IR[31:26];
  assign rs       = IR[25:21];
  assign rt       = IR[20:16];
  assign rd       = IR[15:11];
  assign shamt    = IR[10:6];
  assign funct    = IR[5:0];
  assign sext_imm = {{16{IR[15]}}, IR[15:0]};
  assign zext_imm = {16'h0, IR[15:0]};

  assign is_r     = (op == 6'h00);
  assign r_ok     = (funct inside {6'h00, 6'h02, 6'h03, 6'h08, 6'h20, 6'h21, 6'h22,
                                   6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B});
  assign is_jr    = is_r && (funct == 6'h08);
  assign is_ialu  = (op inside {6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F});
  assign is_lw    = (op == 6'h23);
  assign is_store = (op inside {6'h28, 6'h29, 6'h2B});
  assign is_br    = (op == 6'h04) || (op == 6'h05);
  assign is_j     = (op == 6'h02);
  assign is_jal   = (op == 6'h03);
  assign valid    = (is_r && r_ok) || is_ialu || is_lw || is_store || is_br || is_j || is_jal;
  assign br_taken = (op == 6'h04) ? (A == B) : (A != B);

  assign mem_state = (state == FETCH) || (state == MEM_READ) || (state == MEM_WRITE);
  assign wait_last = (wait_cnt == MEM_WAIT[7:0]);

  mips_regfile rf (
    .clk(clk), .we(rf_we), .waddr(rf_waddr), .wdata(rf_wdata),
    .raddr1(rs), .raddr2(rt), .rdata1(rs_val), .rdata2(rt_val)
  );

  // The single ALU serves PC+4 in FETCH, branch target in DECODE, and the op in EXECUTE.
  always_comb begin
    alu_y = '0;
    case (state)
      FETCH:   alu_y = PC + 32'd4;
      DECODE:  alu_y = PC + {sext_imm[29:0], 2'b00};
      EXECUTE: begin
        if (is_r) begin
          case (funct)
            6'h00:        alu_y = B << shamt;
            6'h02:        alu_y = B >> shamt;
            6'h03:        alu_y = $signed(B) >>> shamt;
            6'h20, 6'h21: alu_y = A + B;
            6'h22, 6'h23: alu_y = A - B;
            6'h24:        alu_y = A & B;
            6'h25:        alu_y = A | B;
            6'h26:        alu_y = A ^ B;
            6'h27:        alu_y = ~(A | B);
            6'h2A:        alu_y = {31'd0, $signed(A) < $signed(B)};
            6'h2B:        alu_y = {31'd0, A < B};
            default:      alu_y = '0;
          endcase
        end else begin
          case (op)
            6'h08, 6'h09:                alu_y = A + sext_imm;
            6'h0A:                       alu_y = {31'd0, $signed(A) < $signed(sext_imm)};
            6'h0B:                       alu_y = {31'd0, A < sext_imm};
            6'h0C:                       alu_y = A & zext_imm;
            6'h0D:                       alu_y = A | zext_imm;
            6'h0E:                       alu_y = A ^ zext_imm;
            6'h0F:                       alu_y = {IR[15:0], 16'h0};
            6'h23, 6'h28, 6'h29, 6'h2B:  alu_y = A + sext_imm;
            default:                     alu_y = '0;
          endcase
        end
      end
      default: alu_y = '0;
    endcase
  end

  always_comb begin
    next_state = state;
    case (state)
      FETCH:     if (wait_last) next_state = DECODE;
      DECODE:    next_state = valid ? EXECUTE : FETCH;
      EXECUTE: begin
        if (is_lw)                          next_state = MEM_READ;
        else if (is_store)                  next_state = MEM_WRITE;
        else if ((is_r && !is_jr) || is_ialu) next_state = WB_ALU;
        else                                next_state = FETCH;
      end
      MEM_READ:  if (wait_last) next_state = WB_MEM;
      MEM_WRITE: if (wait_last) next_state = FETCH;
      default:   next_state = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= FETCH;
      PC       <= RESET_PC;
      wait_cnt <= '0;
    end else begin
      state    <= next_state;
      wait_cnt <= (mem_state && !wait_last) ? wait_cnt + 8'd1 : 8'd0;
      if (state == FETCH && wait_last) PC <= alu_y;
      if (state == EXECUTE) begin
        if (is_br && br_taken)  PC <= ALUOut;
        else if (is_j || is_jal) PC <= {PC[31:28], IR[25:0], 2'b00};
        else if (is_jr)         PC <= A;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == FETCH && wait_last)    IR <= mem_read_data;
    if (state == MEM_READ && wait_last) MDR <= mem_read_data;
    if (state == DECODE) begin
      A <= rs_val;
      B <= rt_val;
    end
    if (state == DECODE || state == EXECUTE) ALUOut <= alu_y;
  end

  // jal links in EXECUTE; PC there already holds the return address.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = rt;
    rf_wdata = ALUOut;
    case (state)
      WB_ALU: begin
        rf_we    = 1'b1;
        rf_waddr = is_r ? rd : rt;
      end
      WB_MEM: begin
        rf_we    = 1'b1;
        rf_wdata = MDR;
      end
      EXECUTE: if (is_jal) begin
        rf_we    = 1'b1;
        rf_waddr = 5'd31;
        rf_wdata = PC;
      end
      default: rf_we = 1'b0;
    endcase
  end

  assign mem_write_data = B;

  always_comb begin
    mem_addr           = '0;
    mem_read           = 1'b0;
    mem_write          = 1'b0;
    mem_write_data_src = 2'b00;
    if (reset) begin
      case (state)
        FETCH: begin
          mem_addr = PC;
          mem_read = 1'b1;
        end
        MEM_READ: begin
          mem_addr = ALUOut;
          mem_read = 1'b1;
        end
        MEM_WRITE: begin
          mem_addr           = ALUOut;
          mem_write          = wait_last;
          mem_write_data_src = (op == 6'h28) ? 2'b01 : (op == 6'h29) ? 2'b10 : 2'b00;
        end
        default: mem_addr = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_multi_cycle_mips_core.sv
// Directed program bench for multi_cycle_mips_core: runs a small program from
// a bench-side word memory and checks registers, stores and bus behaviour.
`timescale 1ns/1ps

module tb_multi_cycle_mips_core;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] mem_addr, mem_read_data, mem_write_data;
  logic        mem_read, mem_write;
  logic [1:0]  mem_write_data_src;

  logic [31:0] mem [1024];
  logic [31:0] exp_q[$];
  logic [31:0] obs_word_q[$];
  logic [31:0] obs_addr_q[$];
  logic [1:0]  obs_src_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          overlap_cycles = 0;
  int          write_cycles = 0;

  multi_cycle_mips_core #(.RESET_PC(32'h0), .MEM_WAIT(3)) dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_read_data(mem_read_data),
    .mem_write_data(mem_write_data), .mem_read(mem_read), .mem_write(mem_write),
    .mem_write_data_src(mem_write_data_src)
  );

  // clock / reset
  always #1.25 clk = ~clk;

  // memory model: combinational read, lane-masked write on the rising edge
  assign mem_read_data = mem[mem_addr[11:2]];

  always @(posedge clk) begin
    if (reset && mem_write) begin
      case (mem_write_data_src)
        2'b01:   mem[mem_addr[11:2]][7:0]  = mem_write_data[7:0];
        2'b10:   mem[mem_addr[11:2]][15:0] = mem_write_data[15:0];
        default: mem[mem_addr[11:2]]       = mem_write_data;
      endcase
      obs_word_q.push_back(mem[mem_addr[11:2]]);
      obs_addr_q.push_back(mem_addr);
      obs_src_q.push_back(mem_write_data_src);
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      if (mem_read && mem_write) overlap_cycles++;
      if (mem_write) write_cycles++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // instruction encoders
  function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'd0, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_ins(input logic [5:0] op, input logic [31:0] addr);
    return {op, addr[27:2]};
  endfunction

  task automatic load_program();
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[0]  = i_ins(6'h08, 5'd0, 5'd8, 16'd5);            // addi $8,$0,5
    mem[1]  = i_ins(6'h08, 5'd0, 5'd9, 16'hFFFD);         // addi $9,$0,-3
    mem[2]  = r_ins(5'd8, 5'd9, 5'd10, 5'd0, 6'h20);      // add $10,$8,$9
    mem[3]  = r_ins(5'd9, 5'd8, 5'd11, 5'd0, 6'h2A);      // slt $11,$9,$8
    mem[4]  = r_ins(5'd9, 5'd8, 5'd12, 5'd0, 6'h2B);      // sltu $12,$9,$8
    mem[5]  = i_ins(6'h0F, 5'd0, 5'd13, 16'h1234);        // lui $13,0x1234
    mem[6]  = i_ins(6'h2B, 5'd0, 5'd10, 16'h0100);        // sw $10,0x100($0)
    mem[7]  = i_ins(6'h23, 5'd0, 5'd14, 16'h0100);        // lw $14,0x100($0)
    mem[8]  = i_ins(6'h0F, 5'd0, 5'd8, 16'h1122);         // lui $8,0x1122
    mem[9]  = i_ins(6'h0D, 5'd8, 5'd8, 16'h3344);         // ori $8,$8,0x3344
    mem[10] = i_ins(6'h28, 5'd0, 5'd8, 16'h0040);         // sb $8,0x40($0)
    mem[11] = i_ins(6'h29, 5'd0, 5'd8, 16'h0040);         // sh $8,0x40($0)
    mem[12] = i_ins(6'h08, 5'd0, 5'd0, 16'd7);            // addi $0,$0,7
    mem[13] = i_ins(6'h04, 5'd8, 5'd8, 16'd1);            // beq $8,$8,+1
    mem[14] = i_ins(6'h08, 5'd0, 5'd10, 16'd99);          // addi $10,$0,99 (skipped)
    mem[15] = j_ins(6'h02, 32'h48);                       // j 0x48
    mem[16] = 32'hAABBCCDD;                               // data word 0x40
    mem[18] = i_ins(6'h05, 5'd8, 5'd8, 16'd1);            // bne $8,$8,+1 (not taken)
    mem[19] = i_ins(6'h08, 5'd0, 5'd17, 16'd9);           // addi $17,$0,9
    mem[20] = j_ins(6'h03, 32'h80);                       // jal 0x80
    mem[21] = i_ins(6'h08, 5'd0, 5'd18, 16'h0055);        // addi $18,$0,0x55
    mem[22] = r_ins(5'd8, 5'd9, 5'd20, 5'd0, 6'h22);      // sub $20,$8,$9
    mem[23] = r_ins(5'd0, 5'd9, 5'd21, 5'd1, 6'h03);      // sra $21,$9,1
    mem[24] = r_ins(5'd0, 5'd9, 5'd22, 5'd28, 6'h02);     // srl $22,$9,28
    mem[25] = r_ins(5'd0, 5'd8, 5'd23, 5'd4, 6'h00);      // sll $23,$8,4
    mem[26] = r_ins(5'd8, 5'd0, 5'd24, 5'd0, 6'h27);      // nor $24,$8,$0
    mem[27] = i_ins(6'h0B, 5'd8, 5'd25, 16'hFFFF);        // sltiu $25,$8,-1
    mem[28] = i_ins(6'h0C, 5'd9, 5'd26, 16'hFFFF);        // andi $26,$9,0xFFFF
    mem[29] = j_ins(6'h02, 32'h200);                      // j 0x200
    mem[32] = i_ins(6'h08, 5'd0, 5'd19, 16'h0077);        // 0x80: addi $19,$0,0x77
    mem[33] = r_ins(5'd31, 5'd0, 5'd0, 5'd0, 6'h08);      // jr $31
  endtask

  initial begin
    int n;
    int cyc;
    logic [31:0] exp_w;
    load_program();
    exp_q.push_back(32'h0000_0002);
    exp_q.push_back(32'hAABB_CC44);
    exp_q.push_back(32'hAABB_3344);

    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);

    // mid-run reset held for 3 cycles
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pc", dut.PC, 32'h0);
    check("rst_mem_read", {31'd0, mem_read}, 32'd0);
    check("rst_mem_write", {31'd0, mem_write}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_src", {30'd0, mem_write_data_src}, 32'd0);
    obs_word_q.delete();
    obs_addr_q.delete();
    obs_src_q.delete();
    reset = 1'b1;
    #0.1;
    check("fetch0_addr", mem_addr, 32'h0);
    check("fetch0_read", {31'd0, mem_read}, 32'd1);

    n = 0;
    while (mem_read && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("fetch_len", n, 32'd4);

    cyc = 0;
    while (dut.PC !== 32'h200 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check("halt_pc", dut.PC, 32'h200);

    check("rf0", dut.rf.rf_data[0], 32'h0);
    check("rf8", dut.rf.rf_data[8], 32'h1122_3344);
    check("rf9", dut.rf.rf_data[9], 32'hFFFF_FFFD);
    check("rf10", dut.rf.rf_data[10], 32'h2);
    check("rf11", dut.rf.rf_data[11], 32'h1);
    check("rf12", dut.rf.rf_data[12], 32'h0);
    check("rf13", dut.rf.rf_data[13], 32'h1234_0000);
    check("rf14", dut.rf.rf_data[14], 32'h2);
    check("rf17", dut.rf.rf_data[17], 32'h9);
    check("rf18", dut.rf.rf_data[18], 32'h55);
    check("rf19", dut.rf.rf_data[19], 32'h77);
    check("rf31", dut.rf.rf_data[31], 32'h54);
    check("rf20_sub", dut.rf.rf_data[20], 32'h1122_3347);
    check("rf21_sra", dut.rf.rf_data[21], 32'hFFFF_FFFE);
    check("rf22_srl", dut.rf.rf_data[22], 32'h0000_000F);
    check("rf23_sll", dut.rf.rf_data[23], 32'h1223_3440);
    check("rf24_nor", dut.rf.rf_data[24], 32'hEEDD_CCBB);
    check("rf25_sltiu", dut.rf.rf_data[25], 32'h1);
    check("rf26_andi", dut.rf.rf_data[26], 32'h0000_FFFD);
    check("mem_100", mem[64], 32'h2);
    check("mem_40", mem[16], 32'hAABB_3344);

    // store scoreboard
    check("wr_count", obs_word_q.size(), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (obs_word_q.size() > 0 && exp_q.size() > 0) begin
        exp_w = exp_q.pop_front();
        check($sformatf("wr%0d_word", i), obs_word_q.pop_front(), exp_w);
        check($sformatf("wr%0d_addr", i), obs_addr_q.pop_front(), (i == 0) ? 32'h100 : 32'h40);
        check($sformatf("wr%0d_src", i), {30'd0, obs_src_q.pop_front()},
              (i == 0) ? 32'd0 : (i == 1) ? 32'd1 : 32'd2);
      end
    end
    check("write_cycles", write_cycles, 32'd3);
    check("rw_overlap", overlap_cycles, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/multi_cycle_mips_core.md
Name: multi_cycle_mips_core

Overview:
Multi-cycle, non-pipelined 32-bit MIPS integer CPU with a single unified instruction/data memory port. It is the top-level processor block: it fetches, decodes and executes one instruction at a time through a shared-ALU state machine, and drives an external asynchronous word memory. The bench halts when the PC reaches the OS entry address 0x200.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
MEM_WAIT, 3, extra cycles each memory access state is held so that read data is valid before capture (memory read latency is about 7 ns; clock period is 2.5 ns).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
mem_addr  output  32  byte address; memory uses bits [11:2].
mem_read_data  input  32  word returned by memory; valid MEM_WAIT cycles after mem_read/mem_addr become stable.
mem_write_data  output  32  store data (rt value, unshifted).
mem_read  output  1  read enable; high during fetch and lw access.
mem_write  output  1  write enable; memory samples it on the rising edge.
mem_write_data_src  output  2  store size: 00 = word, 01 = byte (data[7:0] into word bits [7:0]), 10 = halfword (data[15:0] into word bits [15:0]); 11 is never driven.

Behaviour:
- Internal state: 32-bit register PC (hierarchical name PC), register file rf with a 32x32 array rf_data, and registers IR, MDR, A, B, ALUOut.
- rf_data[0] always reads 0 and ignores writes.
- Reset (reset = 0, asynchronous) sets:
  - PC = RESET_PC, state = FETCH, wait counter = 0.
  - mem_read = 0, mem_write = 0, mem_addr = 0, mem_write_data_src = 00.
  - The register file is not cleared.
  - Reset asserted mid-instruction aborts it; no partial register write occurs after reset is asserted.
- States:
  - FETCH: mem_addr = PC, mem_read = 1, held MEM_WAIT+1 cycles. On the last cycle: IR <= mem_read_data, PC <= PC+4.
  - DECODE: A <= rf[rs], B <= rf[rt], ALUOut <= PC + (sign-extended imm << 2).
  - EXECUTE: behaviour depends on the instruction class.
    - R-type: ALUOut <= A op B; for sll/srl/sra the operand is B shifted by shamt.
    - I-type ALU: imm is sign-extended for addi/addiu/slti/sltiu and zero-extended for andi/ori/xori; lui gives {imm,16'h0}.
    - Memory ops: ALUOut <= A + sign-extended imm.
    - beq/bne: if the condition holds, PC <= ALUOut; then go to FETCH.
    - j: PC <= {PC[31:28], target, 2'b00}; then FETCH.
    - jal: additionally rf[31] <= PC (already PC+4); then FETCH.
    - jr: PC <= A; then FETCH.
  - MEM_READ (lw): mem_addr = ALUOut, mem_read = 1, held MEM_WAIT+1 cycles; MDR captured on the last cycle.
  - MEM_WRITE (sw/sh/sb): mem_addr = ALUOut, mem_write_data = B, and mem_write_data_src = 00 / 10 / 01 respectively.
    - Address and data are held MEM_WAIT+1 cycles.
    - mem_write is high only in the final cycle, so exactly one write edge occurs. Then FETCH.
  - WB_ALU: rf[rd] (R-type) or rf[rt] (I-type) <= ALUOut; then FETCH.
  - WB_MEM: rf[rt] <= MDR; then FETCH.
- Supported opcodes:
  - R-type: add, addu, sub, subu, and, or, xor, nor, slt, sltu, sll, srl, sra, jr.
  - I-type and jumps: addi, addiu, andi, ori, xori, slti, sltiu, lui, lw, sw, sh, sb, beq, bne, j, jal.
- Arithmetic rules:
  - No overflow traps; add and addu behave identically.
  - slt is signed; sltu and sltiu compare unsigned, with sltiu using the sign-extended immediate.
- Unknown opcode or funct: treated as a NOP and returns to FETCH after DECODE.
- No branch delay slots.
- Store addresses are used as given; no alignment checks. sb/sh always write the low lanes of the addressed word.
- Cycle counts with MEM_WAIT = 0: branch/jump 3, ALU 4, store 4, lw 5. Each memory access adds MEM_WAIT cycles.
- mem_read and mem_write are never high simultaneously.

Test Plan:
- Reset: reset low for 3 cycles mid-run -> PC = 0, mem_read = 0, mem_write = 0; after release the first fetch drives mem_addr = 0 with mem_read = 1.
- ALU: addi $8,$0,5; addi $9,$0,-3; add $10,$8,$9; slt $11,$9,$8; sltu $12,$9,$8; lui $13,0x1234 -> rf[10]=2, rf[11]=1, rf[12]=0, rf[13]=0x12340000.
- Memory: sw $10,0x100($0); lw $14,0x100($0) -> rf[14]=2; sw issues exactly one mem_write pulse with mem_write_data_src = 00.
- Partial stores: word 0x40 preset to 0xAABBCCDD; $8 = 0x11223344; sb $8,0x40($0) -> 0xAABBCC44; then sh $8,0x40($0) -> 0xAABB3344.
- Control flow: beq taken skips one instruction; bne not taken falls through; jal 0x80 puts the return address in rf[31] and jr $31 returns there; j 0x200 -> PC becomes 0x200 and the bench stops.
- $0: addi $0,$0,7 -> rf[0] still reads 0.
